tob_publisher: RTL and testbench
================================

Name: tob_publisher

Overview:
- Sits directly downstream of the order book and watches its registered top-of-book outputs (best bid/ask price and qty).
- Emits one snapshot record each time any of the four values changes, with derived spread, doubled mid, flags and sequence number.
- Records are buffered in a small FIFO and delivered to the strategy/algo stage over a valid/ready handshake.
- FIFO overflow is detected, counted and signalled in-band.

Parameters:
- FIFO_DEPTH, 8, snapshot FIFO entries; power of 2, >= 2
- SEQ_BITS, 16, width of snapshot sequence number
- CNT_BITS, 16, width of saturating drop counter

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- enable  input  1  1 = generate snapshots on change; FIFO drains regardless
- best_bid_price  input  32  book best bid price (ticks)
- best_bid_qty  input  32  book best bid qty; 0 = no bid
- best_ask_price  input  32  book best ask price (ticks)
- best_ask_qty  input  32  book best ask qty; 0 = no ask
- out_valid  output  1  head record valid
- out_ready  input  1  consumer accepts head record
- out_bid_price  output  32  snapshot bid price
- out_bid_qty  output  32  snapshot bid qty
- out_ask_price  output  32  snapshot ask price
- out_ask_qty  output  32  snapshot ask qty
- out_spread  output  32  ask-bid, or 0 (see rules)
- out_mid_x2  output  33  bid+ask, or 0
- out_flags  output  4  [0] crossed, [1] bid_empty, [2] ask_empty, [3] gap
- out_seq  output  SEQ_BITS  snapshot sequence number
- drop_count  output  CNT_BITS  saturating count of dropped snapshots
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values:
  - All out_* = 0; out_valid = 0.
  - drop_count = 0, fifo_level = 0, seq counter = 0, gap_pending = 0.
  - Input capture regs and last_seen regs = 0.
- Stage 1: all four inputs are registered into in_q every cycle, unconditionally.
- Stage 2, change detect:
  - event = enable && (in_q != last_seen), comparing all 128 bits.
  - On event, last_seen <= in_q, whether or not the FIFO accepts the record.
  - enable=0: no events and last_seen holds. After enable rises, any difference publishes on the next cycle.
- Latency: an input change present before edge k is pushed at edge k+1. out_valid is high after edge k+1 if the FIFO was empty. Two cycles total.
- Derived fields, computed from in_q at the push:
  - bid_empty = (bid_qty==0); ask_empty = (ask_qty==0); both_present = !bid_empty && !ask_empty.
  - crossed = both_present && bid_price > ask_price. Locked (equal prices) is not crossed.
  - spread = both_present && ask_price >= bid_price ? ask_price - bid_price : 0 (32-bit).
  - mid_x2 = both_present ? {1'b0,bid}+{1'b0,ask} : 0 (33-bit, no overflow).
  - gap = gap_pending.
- Sequence numbers:
  - Every event consumes one seq value, including dropped events. seq increments by 1 and wraps modulo 2^SEQ_BITS.
  - Record seq = counter value before the increment.
- Push acceptance:
  - pop = out_valid && out_ready.
  - Push is accepted when fifo_level < FIFO_DEPTH, or when full and pop is asserted the same cycle.
  - Simultaneous push and pop: level unchanged, data ordering preserved.
- Drop on full:
  - An event that is not accepted is dropped.
  - drop_count increments, saturating at all-ones.
  - gap_pending <= 1.
- gap_pending clears when a record is accepted. That accepted record carries gap=1.
- Output:
  - out_* present the FIFO head.
  - out_valid = (fifo_level != 0).
  - Head data must stay stable while out_valid && !out_ready.
  - No combinational path from out_ready to out_valid.
- Empty FIFO with pop: not possible, since pop requires out_valid.
- Reset mid-operation: FIFO flushed immediately (asynchronously), pending records lost, seq and counters cleared.

Test Plan:
- Single change: after reset, drive bid 10000/qty 5, ask 10002/qty 7 for one step, out_ready=1.
  - Exactly one record two cycles later: spread=2, mid_x2=20002, flags=0000, seq=0.
  - No further records while inputs stay constant.
- Crossed and empty cases:
  - bid 10005/qty 3 with ask 10004/qty 1 -> flags[0]=1, spread=0, mid_x2=20009.
  - Then ask_qty=0 -> flags=0100, spread=0, mid_x2=0.
- Backpressure:
  - Hold out_ready=0 and apply 10 distinct input changes on consecutive cycles -> fifo_level=8, drop_count=2.
  - Release out_ready -> records seq 0..7 come out in order, head stable while stalled.
  - Next new change yields seq=10 with flags[3]=1.
- Full with simultaneous pop:
  - FIFO full, out_ready=1, new change arrives -> push accepted, fifo_level stays 8, drop_count unchanged.
- Enable gating:
  - enable=0 while inputs change 3 times -> no records.
  - Raise enable -> exactly one record holding the current values.
- Reset mid-stream:
  - Assert rst_n=0 with 5 entries queued -> out_valid=0, fifo_level=0, drop_count=0 immediately.
  - After release, the first change yields seq=0.

Source files
------------

// File: rtl/tob_publisher.sv
// Top-of-book snapshot publisher: detects changes in the book's best bid/ask,
// builds derived snapshot records and queues them for the strategy stage.
module tob_publisher #(
    parameter int FIFO_DEPTH = 8,
    parameter int SEQ_BITS   = 16,
    parameter int CNT_BITS   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [31:0]                  best_bid_price,
    input  logic [31:0]                  best_bid_qty,
    input  logic [31:0]                  best_ask_price,
    input  logic [31:0]                  best_ask_qty,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_bid_price,
    output logic [31:0]                  out_bid_qty,
    output logic [31:0]                  out_ask_price,
    output logic [31:0]                  out_ask_qty,
    output logic [31:0]                  out_spread,
    output logic [32:0]                  out_mid_x2,
    output logic [3:0]                   out_flags,
    output logic [SEQ_BITS-1:0]          out_seq,
    output logic [CNT_BITS-1:0]          drop_count,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    logic [31:0] bid_price_q, bid_qty_q, ask_price_q, ask_qty_q;
    logic [127:0] last_seen;
    logic [127:0] in_cat;
    logic [SEQ_BITS-1:0] seq_cnt;
    logic gap_pending;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;

    logic [31:0]         mem_bid_price [FIFO_DEPTH];
    logic [31:0]         mem_bid_qty   [FIFO_DEPTH];
    logic [31:0]         mem_ask_price [FIFO_DEPTH];
    logic [31:0]         mem_ask_qty   [FIFO_DEPTH];
    logic [31:0]         mem_spread    [FIFO_DEPTH];
    logic [32:0]         mem_mid_x2    [FIFO_DEPTH];
    logic [3:0]          mem_flags     [FIFO_DEPTH];
    logic [SEQ_BITS-1:0] mem_seq       [FIFO_DEPTH];

    logic evt, pop, push, full;
    logic bid_empty, ask_empty, both_present, crossed;
    logic [31:0] spread;
    logic [32:0] mid_x2;
    logic [3:0]  flags;

    assign in_cat = {bid_price_q, bid_qty_q, ask_price_q, ask_qty_q};
    assign evt    = enable && (in_cat != last_seen);
    assign full   = (level == DEPTH_L);
    assign pop    = out_valid && out_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push   = evt && (!full || pop);

    assign bid_empty    = (bid_qty_q == 32'd0);
    assign ask_empty    = (ask_qty_q == 32'd0);
    assign both_present = !bid_empty && !ask_empty;
    assign crossed      = both_present && (bid_price_q > ask_price_q);
    assign spread       = (both_present && (ask_price_q >= bid_price_q)) ?
                          (ask_price_q - bid_price_q) : 32'd0;
    assign mid_x2       = both_present ? ({1'b0, bid_price_q} + {1'b0, ask_price_q}) : 33'd0;
    assign flags        = {gap_pending, ask_empty, bid_empty, crossed};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bid_price_q <= '0;
            bid_qty_q   <= '0;
            ask_price_q <= '0;
            ask_qty_q   <= '0;
        end else begin
            bid_price_q <= best_bid_price;
            bid_qty_q   <= best_bid_qty;
            ask_price_q <= best_ask_price;
            ask_qty_q   <= best_ask_qty;
        end
    end

    // Every event consumes a sequence number and updates last_seen, even when dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_seen   <= '0;
            seq_cnt     <= '0;
            drop_count  <= '0;
            gap_pending <= 1'b0;
        end else begin
            if (evt) begin
                last_seen <= in_cat;
                seq_cnt   <= seq_cnt + 1'b1;
            end
            if (push) begin
                gap_pending <= 1'b0;
            end else if (evt) begin
                gap_pending <= 1'b1;
                if (!(&drop_count)) drop_count <= drop_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_bid_price[i] <= '0;
                mem_bid_qty[i]   <= '0;
                mem_ask_price[i] <= '0;
                mem_ask_qty[i]   <= '0;
                mem_spread[i]    <= '0;
                mem_mid_x2[i]    <= '0;
                mem_flags[i]     <= '0;
                mem_seq[i]       <= '0;
            end
        end else if (push) begin
            mem_bid_price[wr_ptr] <= bid_price_q;
            mem_bid_qty[wr_ptr]   <= bid_qty_q;
            mem_ask_price[wr_ptr] <= ask_price_q;
            mem_ask_qty[wr_ptr]   <= ask_qty_q;
            mem_spread[wr_ptr]    <= spread;
            mem_mid_x2[wr_ptr]    <= mid_x2;
            mem_flags[wr_ptr]     <= flags;
            mem_seq[wr_ptr]       <= seq_cnt;
        end
    end

    // Head is read straight from storage; out_valid depends only on registered level.
    assign out_valid     = (level != '0);
    assign fifo_level    = level;
    assign out_bid_price = mem_bid_price[rd_ptr];
    assign out_bid_qty   = mem_bid_qty[rd_ptr];
    assign out_ask_price = mem_ask_price[rd_ptr];
    assign out_ask_qty   = mem_ask_qty[rd_ptr];
    assign out_spread    = mem_spread[rd_ptr];
    assign out_mid_x2    = mem_mid_x2[rd_ptr];
    assign out_flags     = mem_flags[rd_ptr];
    assign out_seq       = mem_seq[rd_ptr];

endmodule

// File: tb/tb_tob_publisher.sv
// Bench for tob_publisher: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tob_publisher;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b1;
    logic out_ready = 1'b1;
    logic [31:0] bp = '0, bq = '0, ap = '0, aq = '0;

    logic        out_valid;
    logic [31:0] out_bid_price, out_bid_qty, out_ask_price, out_ask_qty, out_spread;
    logic [32:0] out_mid_x2;
    logic [3:0]  out_flags;
    logic [15:0] out_seq, drop_count;
    logic [3:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    tob_publisher #(.FIFO_DEPTH(DEPTH), .SEQ_BITS(16), .CNT_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .best_bid_price(bp), .best_bid_qty(bq), .best_ask_price(ap), .best_ask_qty(aq),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bid_price(out_bid_price), .out_bid_qty(out_bid_qty),
        .out_ask_price(out_ask_price), .out_ask_qty(out_ask_qty),
        .out_spread(out_spread), .out_mid_x2(out_mid_x2), .out_flags(out_flags),
        .out_seq(out_seq), .drop_count(drop_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bp, bq, ap, aq, spread;
        logic [32:0] mid;
        logic [3:0]  flags;
        logic [15:0] seq;
    } rec_t;

    rec_t        q[$];
    logic [31:0] m_bp = '0, m_bq = '0, m_ap = '0, m_aq = '0;
    logic [127:0] m_last = '0;
    logic [15:0] m_seq = '0, m_drop = '0;
    logic        m_gap = 1'b0;

    // Reference model: a snapshot is what the book looked like one cycle ago,
    // published whenever it differs from the last published view.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                m_bp = '0; m_bq = '0; m_ap = '0; m_aq = '0;
                m_last = '0; m_seq = '0; m_drop = '0; m_gap = 1'b0;
            end else begin
                bit pop, ev, both;
                rec_t r;
                pop = (q.size() != 0) && out_ready;
                ev  = enable && ({m_bp, m_bq, m_ap, m_aq} != m_last);
                if (pop) void'(q.pop_front());
                if (ev) begin
                    both     = (m_bq != 0) && (m_aq != 0);
                    r.bp     = m_bp; r.bq = m_bq; r.ap = m_ap; r.aq = m_aq;
                    r.spread = (both && m_ap >= m_bp) ? m_ap - m_bp : 32'd0;
                    r.mid    = both ? 33'(m_bp) + 33'(m_ap) : 33'd0;
                    r.flags  = {m_gap, m_aq == 0, m_bq == 0, both && (m_bp > m_ap)};
                    r.seq    = m_seq;
                    m_last   = {m_bp, m_bq, m_ap, m_aq};
                    m_seq    = m_seq + 16'd1;
                    if (q.size() < DEPTH) begin
                        q.push_back(r);
                        m_gap = 1'b0;
                    end else begin
                        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                        m_gap = 1'b1;
                    end
                end
                m_bp = bp; m_bq = bq; m_ap = ap; m_aq = aq;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if (out_valid !== (q.size() != 0) || fifo_level !== 4'(q.size())) begin
                    errors++;
                    $display("FAIL occupancy t=%0t: valid=%0b level=%0d, required valid=%0b level=%0d",
                             $time, out_valid, fifo_level, q.size() != 0, q.size());
                end
                checks++;
                if (drop_count !== m_drop) begin
                    errors++;
                    $display("FAIL drop_count t=%0t: got %0d, required %0d", $time, drop_count, m_drop);
                end
                if (q.size() != 0) begin
                    checks++;
                    if (out_bid_price !== q[0].bp || out_bid_qty !== q[0].bq ||
                        out_ask_price !== q[0].ap || out_ask_qty !== q[0].aq ||
                        out_spread !== q[0].spread || out_mid_x2 !== q[0].mid ||
                        out_flags !== q[0].flags || out_seq !== q[0].seq) begin
                        errors++;
                        $display("FAIL head t=%0t: got %0d/%0d %0d/%0d sp=%0d mid=%0d fl=%b seq=%0d, required %0d/%0d %0d/%0d sp=%0d mid=%0d fl=%b seq=%0d",
                                 $time, out_bid_price, out_bid_qty, out_ask_price, out_ask_qty,
                                 out_spread, out_mid_x2, out_flags, out_seq,
                                 q[0].bp, q[0].bq, q[0].ap, q[0].aq, q[0].spread, q[0].mid,
                                 q[0].flags, q[0].seq);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before t=2000000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] b_p, b_q, a_p, a_q);
        bp = b_p; bq = b_q; ap = a_p; aq = a_q;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        cyc(3);
        chk("reset_valid", 64'(out_valid), 0);
        chk("reset_level", 64'(fifo_level), 0);
        chk("reset_bid_price", 64'(out_bid_price), 0);
        rst_n = 1'b1;
        cyc(2);

        // Single change, two-cycle latency.
        set_in(10000, 5, 10002, 7);
        @(negedge clk);
        chk("single_not_yet", 64'(out_valid), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("single_valid", 64'(out_valid), 1);
        chk("single_spread", 64'(out_spread), 2);
        chk("single_mid", 64'(out_mid_x2), 20002);
        chk("single_flags", 64'(out_flags), 0);
        chk("single_seq", 64'(out_seq), 0);
        cyc(6);
        chk("single_no_repeat", 64'(out_valid), 0);

        // Crossed, then ask empty.
        set_in(10005, 3, 10004, 1);
        cyc(2);
        chk("crossed_flags", 64'(out_flags), 4'b0001);
        chk("crossed_spread", 64'(out_spread), 0);
        chk("crossed_mid", 64'(out_mid_x2), 20009);
        cyc(4);
        set_in(10005, 3, 10004, 0);
        cyc(2);
        chk("askempty_flags", 64'(out_flags), 4'b0100);
        chk("askempty_spread", 64'(out_spread), 0);
        chk("askempty_mid", 64'(out_mid_x2), 0);
        chk("askempty_seq", 64'(out_seq), 2);
        cyc(4);

        // Backpressure with overflow.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_in(32'(20000 + i), 4, 32'(20100 + i), 6);
            cyc(1);
        end
        cyc(2);
        chk("bp_level", 64'(fifo_level), 8);
        chk("bp_drops", 64'(drop_count), 2);
        cyc(3);
        chk("bp_head_stable", 64'(out_seq), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bp_drain_seq", 64'(out_seq), 64'(i));
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_in(30000, 2, 30010, 2);
        cyc(2);
        chk("gap_seq", 64'(out_seq), 10);
        chk("gap_flag", 64'(out_flags[3]), 1);
        out_ready = 1'b1;
        cyc(3);

        // Full FIFO with pop on the same edge as the push.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_in(32'(40000 + i), 1, 32'(40050 + i), 1);
            cyc(1);
        end
        cyc(3);
        chk("full_level", 64'(fifo_level), 8);
        set_in(50000, 9, 50001, 9);
        cyc(1);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        chk("full_pop_level", 64'(fifo_level), 8);
        chk("full_pop_drops", 64'(drop_count), 2);
        out_ready = 1'b1;
        cyc(12);

        // Enable gating.
        enable = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(32'(60000 + i), 3, 60100, 3);
            cyc(1);
        end
        cyc(3);
        chk("gated_no_records", 64'(out_valid), 0);
        enable = 1'b1;
        cyc(2);
        chk("enable_level", 64'(fifo_level), 1);
        chk("enable_bid", 64'(out_bid_price), 60002);
        out_ready = 1'b1;
        cyc(3);

        // Asynchronous reset with records queued.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(32'(70000 + i), 1, 70100, 1);
            cyc(1);
        end
        cyc(3);
        chk("mid_level", 64'(fifo_level), 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(out_valid), 0);
        chk("async_level", 64'(fifo_level), 0);
        chk("async_drops", 64'(drop_count), 0);
        set_in(0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1);
        set_in(80000, 2, 80004, 2);
        cyc(2);
        chk("post_reset_valid", 64'(out_valid), 1);
        chk("post_reset_seq", 64'(out_seq), 0);
        out_ready = 1'b1;
        cyc(3);

        // Randomized traffic with varying backpressure.
        for (int s = 0; s < 24; s++) begin
            for (int c = 0; c < 120; c++) begin
                enable    = ($urandom % 8) != 0;
                out_ready = ($urandom % 4) < (s % 4);
                if ($urandom % 2 == 0) begin
                    if ($urandom % 16 == 0)
                        set_in(32'hFFFF_FFF0 + ($urandom % 4), $urandom % 3,
                               32'hFFFF_FFF0 + ($urandom % 4), $urandom % 3);
                    else
                        set_in(100 + ($urandom % 4), $urandom % 3,
                               100 + ($urandom % 4), $urandom % 3);
                end
                cyc(1);
            end
        end
        enable = 1'b1;
        out_ready = 1'b1;
        cyc(12);
        chk("final_drained", 64'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
